ascon_inv_substitution_serial: RTL and testbench

//  Inverse of the Ascon 5-bit S-box layer (SP 800-232 p_S^-1), applied column-serially over the 320-bit state.

---
 rtl/ascon_pkg.sv | 46 ++++
 rtl/ascon_inv_sbox5.sv | 16 +
 rtl/ascon_inv_substitution_serial.sv | 129 ++++++++++++
 tb/tb_ascon_inv_substitution_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pkg
// Shared Ascon definitions:
//   ascon_state_t : 320-bit state as five 64-bit words, word 0 = x0
//   SBOX / INV_SBOX : forward and inverse 5-bit S-box tables
//   col_pack / col_unpack : move a bit-column {x0[j],..,x4[j]} (x0 = MSB)
//                           out of / into a state
// ---------------------------------------------------------------------------
package ascon_pkg;

   localparam int NUM_WORDS  = 5;
   localparam int WORD_WIDTH = 64;

   typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;

   localparam logic [4:0] SBOX [0:31] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   localparam logic [4:0] INV_SBOX [0:31] = '{
      5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
      5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
      5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
      5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
   };

   function automatic logic [4:0] col_pack(input ascon_state_t s, input logic [5:0] j);
      return {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
   endfunction

   function automatic ascon_state_t col_unpack(input ascon_state_t s, input logic [5:0] j,
                                               input logic [4:0] c);
      ascon_state_t r;
      r       = s;
      r[0][j] = c[4];
      r[1][j] = c[3];
      r[2][j] = c[2];
      r[3][j] = c[1];
      r[4][j] = c[0];
      return r;
   endfunction

endpackage

// File: rtl/ascon_inv_sbox5.sv
// ---------------------------------------------------------------------------
// ascon_inv_sbox5
// Combinational 5-bit inverse Ascon S-box lookup.
//   col_i : input column {x0,x1,x2,x3,x4}
//   col_o : INV_SBOX[col_i], same bit order
// ---------------------------------------------------------------------------
module ascon_inv_sbox5
   import ascon_pkg::*;
(
   input  logic [4:0] col_i,
   output logic [4:0] col_o
);

   assign col_o = INV_SBOX[col_i];

endmodule

// File: rtl/ascon_inv_substitution_serial.sv
// ---------------------------------------------------------------------------
// ascon_inv_substitution_serial
// Column-serial inverse Ascon substitution layer over the 320-bit state,
// COLS_PER_CYCLE columns per clock, valid/ready on both sides.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   state_i/valid_i/ready_o : input state handshake
//   state_o/valid_o/ready_i : result handshake; state_o stable while valid_o
//   err_o             : sticky forward-S-box cross-check mismatch, present only
//                       when ASCON_INV_SBOX_SELFCHECK_EN is defined
// ---------------------------------------------------------------------------
module ascon_inv_substitution_serial
   import ascon_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  ascon_state_t state_i,
   input  logic         valid_i,
   output logic         ready_o,
   output ascon_state_t state_o,
   output logic         valid_o,
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
   output logic         err_o,
`endif
   input  logic         ready_i
);

   localparam int GROUPS = WORD_WIDTH / COLS_PER_CYCLE;
   localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

   fsm_t              state_q, state_d;
   logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
   ascon_state_t      work_q, work_d;
   logic [5:0]        base;
   logic [4:0]        in_col  [COLS_PER_CYCLE];
   logic [4:0]        out_col [COLS_PER_CYCLE];

   // First column of the group handled this cycle.
   assign base = 6'(int'(col_cnt_q) * COLS_PER_CYCLE);

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lut
      assign in_col[g] = col_pack(work_q, base + 6'(g));
      ascon_inv_sbox5 u_inv (
         .col_i (in_col[g]),
         .col_o (out_col[g])
      );
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      work_d    = work_q;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               work_d    = state_i;
               col_cnt_d = '0;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
               work_d = col_unpack(work_d, base + 6'(g), out_col[g]);
            end
            if (col_cnt_q == CNT_W'(GROUPS - 1)) begin
               col_cnt_d = '0;
               state_d   = DONE;
            end else begin
               col_cnt_d = col_cnt_q + 1'b1;
            end
         end
         DONE: begin
            valid_o = 1'b1;
            if (ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         col_cnt_q <= '0;
         // NOTE: the data register is reset too, because state_o must read
         // zero after reset and partial results must not leak out.
         work_q    <= '0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         work_q    <= work_d;
      end
   end

   assign state_o = work_q;

`ifdef ASCON_INV_SBOX_SELFCHECK_EN
   // Re-apply the forward S-box to each freshly inverted column; it must
   // reproduce the column that went in.
   logic mismatch;
   logic err_q;

   always_comb begin
      mismatch = 1'b0;
      if (state_q == BUSY) begin
         for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            if (SBOX[out_col[g]] != in_col[g]) mismatch = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_q | mismatch;
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ascon_inv_substitution_serial.sv
// ---------------------------------------------------------------------------
// tb_ascon_inv_substitution_serial
// Drives three instances (COLS_PER_CYCLE = 1, 8, 64) from shared stimulus and
// checks results, latency and handshake against a column-wise table model.
// ---------------------------------------------------------------------------
module tb_ascon_inv_substitution_serial;
   import ascon_pkg::*;

   localparam int NDUT = 3;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   ascon_state_t state_i = '0;
   logic         valid_i = 1'b0;
   logic         ready_i = 1'b1;
   logic         ro [NDUT];
   logic         vo [NDUT];
   ascon_state_t so [NDUT];
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
   logic         eo [NDUT];
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic int cpc_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 8 : 64;
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ascon_inv_substitution_serial #(.COLS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 8 : 64)) dut (
         .clk_i   (clk),
         .rst_i   (rst_i),
         .state_i (state_i),
         .valid_i (valid_i),
         .ready_o (ro[g]),
         .state_o (so[g]),
         .valid_o (vo[g]),
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
         .err_o   (eo[g]),
`endif
         .ready_i (ready_i)
      );
   end

   // Reference tables: the inverse table as published, forward derived from it.
   logic [4:0] inv_tab [0:31] = '{
      5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
      5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
      5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
      5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
   };
   logic [4:0] fwd_tab [0:31];

   // Whole-state model: every column through the chosen table.
   function automatic ascon_state_t map_state(input ascon_state_t s, input bit inverse);
      ascon_state_t r = '0;
      for (int j = 0; j < 64; j++) begin
         int v = 16 * s[0][j] + 8 * s[1][j] + 4 * s[2][j] + 2 * s[3][j] + s[4][j];
         int m = inverse ? int'(inv_tab[v]) : int'(fwd_tab[v]);
         for (int w = 0; w < 5; w++) r[w][j] = m[4 - w];
      end
      return r;
   endfunction

   function automatic ascon_state_t rand_state();
      ascon_state_t r;
      for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
      return r;
   endfunction

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One transaction into all instances with ready_i=1; checks result,
   // latency 64/C and the return to IDLE the cycle after valid_o.
   task automatic run_txn(input ascon_state_t s, input ascon_state_t e, input string nm);
      int  got_t [NDUT];
      bit  got   [NDUT];
      bit  idled [NDUT];
      int  w = 0;
      while (!(ro[0] && ro[1] && ro[2]) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({nm, " idle_wait"}, 320'(w < 100), 320'(1));
      for (int i = 0; i < NDUT; i++) begin got[i] = 0; idled[i] = 0; got_t[i] = 0; end
      state_i = s;
      valid_i = 1'b1;
      for (int t = 0; t < 80; t++) begin
         @(negedge clk);
         valid_i = 1'b0;
         if (t == 0) begin
            check({nm, " no_bypass"}, 320'({vo[0], vo[1], vo[2]}), 320'(0));
            check({nm, " busy_ready"}, 320'({ro[0], ro[1], ro[2]}), 320'(0));
         end
         for (int i = 0; i < NDUT; i++) begin
            if (!got[i] && vo[i]) begin
               got[i]   = 1;
               got_t[i] = t;
               check($sformatf("%s c%0d latency", nm, cpc_of(i)), 320'(t), 320'(64 / cpc_of(i)));
               check($sformatf("%s c%0d state", nm, cpc_of(i)), so[i], e);
            end else if (got[i] && !idled[i] && t == got_t[i] + 1) begin
               idled[i] = 1;
               check($sformatf("%s c%0d back_idle", nm, cpc_of(i)),
                     320'({vo[i], ro[i]}), 320'(2'b01));
            end
         end
         if (idled[0] && idled[1] && idled[2]) break;
      end
      for (int i = 0; i < NDUT; i++)
         if (!idled[i]) check($sformatf("%s c%0d timeout", nm, cpc_of(i)), 320'(0), 320'(1));
   endtask

   typedef struct {
      string        name;
      ascon_state_t in;
      ascon_state_t exp;
   } vec_t;

   vec_t vecs [4];

   initial begin
      ascon_state_t s, e;

      for (int i = 0; i < 32; i++) fwd_tab[inv_tab[i]] = 5'(i);

      vecs[0].name = "all_zero"; vecs[0].in = '0; vecs[0].exp = '0;
      vecs[0].exp[0] = '1; vecs[0].exp[2] = '1;
      vecs[1].name = "all_ones"; vecs[1].in = '1; vecs[1].exp = '0;
      vecs[1].exp[3] = '1;
      vecs[2].name = "x0_only";  vecs[2].in = '0; vecs[2].in[0] = '1; vecs[2].exp = '0;
      vecs[2].exp[0] = '1; vecs[2].exp[1] = '1;
      vecs[3].name = "x4_only";  vecs[3].in = '0; vecs[3].in[4] = '1; vecs[3].exp = '0;
      vecs[3].exp[0] = '1; vecs[3].exp[1] = '1; vecs[3].exp[3] = '1;

      // Reset state.
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("reset c%0d handshake", cpc_of(i)), 320'({vo[i], ro[i]}), 320'(2'b01));
         check($sformatf("reset c%0d state_o", cpc_of(i)), so[i], '0);
      end

      // Table-driven constant vectors.
      for (int v = 0; v < 4; v++) run_txn(vecs[v].in, vecs[v].exp, vecs[v].name);

      // Random direct vectors against the inverse model.
      for (int n = 0; n < 20; n++) begin
         s = rand_state();
         run_txn(s, map_state(s, 1'b1), "rand_inv");
      end

      // Round trip: forward-substituted random state must come back unchanged.
      for (int n = 0; n < 250; n++) begin
         s = rand_state();
         run_txn(map_state(s, 1'b0), s, "roundtrip");
      end

      // Backpressure: hold ready_i low in DONE for 20 cycles.
      s = rand_state();
      e = map_state(s, 1'b1);
      ready_i = 1'b0;
      state_i = s;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (64) @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         check($sformatf("bp hold %0d", c), {vo[1], ro[1]}, 2'b10);
         check($sformatf("bp state %0d", c), so[1], e);
         @(negedge clk);
      end
      check("bp c1 state", so[0], e);
      check("bp c64 state", so[2], e);
      ready_i = 1'b1;
      @(negedge clk);
      check("bp release", {vo[0], ro[0], vo[1], ro[1], vo[2], ro[2]}, 6'b010101);

      // Reset while the C=8 instance is in BUSY with col_cnt=3.
      s = rand_state();
      state_i = s;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("midreset c8 handshake", {vo[1], ro[1]}, 2'b01);
      check("midreset c8 state_o", so[1], '0);
      s = rand_state();
      run_txn(s, map_state(s, 1'b1), "after_reset");

`ifdef ASCON_INV_SBOX_SELFCHECK_EN
      for (int i = 0; i < NDUT; i++)
         check($sformatf("selfcheck c%0d err_o", cpc_of(i)), 320'(eo[i]), 320'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
